// File: rtl/ps2_key_fifo.sv
// -----------------------------------------------------------------------------
// ps2_key_fifo
//
// PS/2 keyboard receiver with a tagged key-event FIFO and a raw-byte history.
// The PS/2 clock and data lines are synchronised, and the clock is deglitched.
// Each 11-bit frame is checked for its start, odd-parity and stop bits.
// A frame that stalls is aborted on a timeout. Valid bytes are shifted into a
// history register for a 7-segment display. The E0 and F0 prefixes are folded
// into {ext, brk, code} events, which are held in a first-word-fall-through
// FIFO.
//
// Ports:
//   clk        system clock
//   clrn       asynchronous active-low reset
//   ps2c/ps2d  raw PS/2 clock and data (asynchronous)
//   rd_en      pop the head event (ignored while empty)
//   dout       head event {ext, brk, code[7:0]}; valid while empty=0
//   empty/full FIFO status
//   count      number of events held
//   byte_rdy   one-cycle pulse per valid raw byte
//   hist       raw byte history; newest byte in [7:0]
//   overflow   sticky: an event was dropped because the FIFO was full
//   frame_err  sticky: bad start/parity/stop bit, or frame timeout
//   clr_err    synchronous clear of overflow and frame_err (a new error wins)
// -----------------------------------------------------------------------------
module ps2_key_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int HIST_BYTES = 4,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rd_en,
  output logic [9:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          byte_rdy,
  output logic [8*HIST_BYTES-1:0]       hist,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = 8 * HIST_BYTES;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic          c_meta_q, c_meta_d, c_sync_q, c_sync_d;
  logic          d_meta_q, d_meta_d, d_sync_q, d_sync_d;
  logic          c_f_q, c_f_d, c_f_dly_q, c_f_dly_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_s;

  // Synchronise both lines and let c_f follow ps2c only after a stable run.
  always_comb begin
    c_meta_d   = ps2c;
    c_sync_d   = c_meta_q;
    d_meta_d   = ps2d;
    d_sync_d   = d_meta_q;
    c_f_dly_d  = c_f_q;
    c_f_d      = c_f_q;
    filt_cnt_d = filt_cnt_q;
    if (c_sync_q == c_f_q) begin
      // Any sample that agrees with c_f restarts the run of differing samples.
      filt_cnt_d = {FW{1'b0}};
    end else if (filt_cnt_q == FILT_MAX) begin
      c_f_d      = c_sync_q;
      filt_cnt_d = {FW{1'b0}};
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  // Conditioning registers; both lines idle high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      c_meta_q   <= 1'b1;
      c_sync_q   <= 1'b1;
      d_meta_q   <= 1'b1;
      d_sync_q   <= 1'b1;
      c_f_q      <= 1'b1;
      c_f_dly_q  <= 1'b1;
      filt_cnt_q <= {FW{1'b0}};
    end else begin
      c_meta_q   <= c_meta_d;
      c_sync_q   <= c_sync_d;
      d_meta_q   <= d_meta_d;
      d_sync_q   <= d_sync_d;
      c_f_q      <= c_f_d;
      c_f_dly_q  <= c_f_dly_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  assign fall_s = c_f_dly_q & ~c_f_q;

  // ---------------------------------------------------------------------------
  // Frame FSM, timeout and raw-byte history
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [HW-1:0] hist_q, hist_d;
  logic          frame_set_s;
  logic          bad_byte_s;

  // Next-state logic for the frame receiver; a timeout outranks an idle line.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_d       = par_q;
    byte_rdy_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    hist_d      = hist_q;
    frame_set_s = 1'b0;
    bad_byte_s  = 1'b0;

    if (fall_s) begin
      to_cnt_d = {TW{1'b0}};
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (fall_s) begin
      case (state_q)
        IDLE: begin
          if (d_sync_q == 1'b0) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_set_s = 1'b1;
          end
        end
        DATA: begin
          data_d[bit_cnt_q] = d_sync_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = PAR;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PAR: begin
          par_d   = d_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (parity_ok(data_q, par_q) && d_sync_q) begin
            byte_rdy_d = 1'b1;
            rx_byte_d  = data_q;
            hist_d     = (hist_q << 4'd8) | HW'(data_q);
          end else begin
            frame_set_s = 1'b1;
            bad_byte_s  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if ((state_q != IDLE) && (to_cnt_q == TO_MAX)) begin
      // Stalled partial frame: drop it and wait for a new start bit.
      state_d     = IDLE;
      frame_set_s = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // Frame receiver registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      data_q     <= 8'd0;
      par_q      <= 1'b0;
      to_cnt_q   <= {TW{1'b0}};
      byte_rdy_q <= 1'b0;
      rx_byte_q  <= 8'd0;
      hist_q     <= {HW{1'b0}};
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      byte_rdy_q <= byte_rdy_d;
      rx_byte_q  <= rx_byte_d;
      hist_q     <= hist_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder, event FIFO and sticky error flags
  // ---------------------------------------------------------------------------
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic          push_s, pop_s, wr_ok_s, drop_s;
  logic [9:0]    event_s;

  // Decode the byte in its byte_rdy cycle, then apply the push and pop.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    push_s   = 1'b0;
    event_s  = {ext_q, brk_q, rx_byte_q};
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (byte_rdy_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push_s = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end

    // A corrupt byte breaks any prefix sequence in progress.
    if (bad_byte_s) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else begin
      ext_d = ext_d;
    end

    pop_s = rd_en & ~empty_q;
    // When full, a push only lands if a pop frees the head slot this cycle.
    wr_ok_s = push_s & (~full_q | pop_s);
    drop_s  = push_s & full_q & ~pop_s;

    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = event_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_ok_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !wr_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == DEPTH_C);

    // A new error outranks a clear in the same cycle.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (frame_set_s) begin
      frame_err_d = 1'b1;
    end else if (clr_err) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Decoder, FIFO storage and status registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // First-word-fall-through: the head entry is read straight from storage.
  assign dout      = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign byte_rdy  = byte_rdy_q;
  assign hist      = hist_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_fifo
//
// Self-checking bench for ps2_key_fifo. A small model tracks prefixes, history,
// FIFO occupancy and sticky flags. Expected events are queued as frames are sent
// and compared against dout when they are popped.
// -----------------------------------------------------------------------------
module tb_ps2_key_fifo;

  localparam int DEPTH = 8;
  localparam int HB    = 4;

  logic        clk = 1'b0;
  logic        clrn, ps2c, ps2d, rd_en, clr_err;
  logic [9:0]  dout;
  logic        empty, full, byte_rdy, overflow, frame_err;
  logic [3:0]  count;
  logic [31:0] hist;

  int checks   = 0;
  int failures = 0;
  int rdy_cnt  = 0;

  // Model state
  logic [9:0]  exp_q[$];
  int          m_cnt, m_rdy;
  logic        m_ext, m_brk, m_ferr, m_ovf;
  logic [31:0] m_hist;

  ps2_key_fifo #(
    .FIFO_DEPTH(DEPTH),
    .HIST_BYTES(HB),
    .FILTER_LEN(4),
    .TIMEOUT(2000)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count),
    .byte_rdy(byte_rdy),
    .hist(hist),
    .overflow(overflow),
    .frame_err(frame_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Count cycles with byte_rdy high; a proper pulse adds one per valid byte.
  always @(posedge clk) begin
    if (byte_rdy) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (100) @(negedge clk);
    ps2c = 1'b0;
    repeat (200) @(negedge clk);
    ps2c = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (20) @(negedge clk);
    // Model update
    if (bad_par) begin
      m_ferr = 1'b1;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else begin
      m_rdy++;
      m_hist = {m_hist[23:0], b};
      if (b == 8'hE0) begin
        m_ext = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        if (m_cnt < DEPTH) begin
          exp_q.push_back({m_ext, m_brk, b});
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_notempty"}, {31'd0, empty}, 32'd0);
      check_eq({tag, "_dout"}, {22'd0, dout}, {22'd0, e});
      m_cnt--;
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clr_errs();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_hist"}, hist, m_hist);
    check_eq({tag, "_count"}, {28'd0, count}, 32'(m_cnt));
    check_eq({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, m_ferr});
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    check_eq({tag, "_rdy"}, 32'(rdy_cnt), 32'(m_rdy));
  endtask

  initial begin
    clrn = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    m_cnt = 0; m_rdy = 0; m_ext = 1'b0; m_brk = 1'b0;
    m_ferr = 1'b0; m_ovf = 1'b0; m_hist = 32'd0;
    repeat (5) @(negedge clk);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_dout", {22'd0, dout}, 32'd0);
    check_eq("rst_byte_rdy", {31'd0, byte_rdy}, 32'd0);
    check_state("rst");
    clrn = 1'b1;
    repeat (20) @(negedge clk);

    // Make code A
    send_frame(8'h1C, 1'b0);
    check_state("make_a");
    pop_check("make_a");
    check_eq("make_a_empty", {31'd0, empty}, 32'd1);

    // Extended break, right arrow
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    check_state("ext_brk");
    pop_check("ext_brk");

    // Bad parity, then a normal break sequence
    send_frame(8'h1C, 1'b1);
    check_state("bad_par");
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_state("brk_1c");
    pop_check("brk_1c");
    clr_errs();
    check_eq("clr_ferr", {31'd0, frame_err}, 32'd0);

    // Stalled frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (2500) @(negedge clk);
    m_ferr = 1'b1;
    check_state("stall");
    check_eq("stall_idle", 32'(dut.state_q), 32'd0);
    send_frame(8'h29, 1'b0);
    check_state("after_stall");
    pop_check("after_stall");
    clr_errs();

    // Overflow
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    check_eq("ovf_full", {31'd0, full}, 32'd1);
    check_state("ovf");
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_pop");
    check_eq("ovf_drained", {31'd0, empty}, 32'd1);
    clr_errs();
    check_eq("ovf_clr", {31'd0, overflow}, 32'd0);

    // Short glitch on ps2c while idle
    @(negedge clk);
    ps2c = 1'b0;
    repeat (2) @(negedge clk);
    ps2c = 1'b1;
    repeat (50) @(negedge clk);
    check_state("glitch");
    check_eq("glitch_idle", 32'(dut.state_q), 32'd0);

    // Reset mid-DATA
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    check_eq("rst_mid_data", 32'(dut.state_q), 32'd1);
    #2 clrn = 1'b0;
    #20;
    m_hist = 32'd0; m_ext = 1'b0; m_brk = 1'b0; m_cnt = 0;
    exp_q.delete();
    check_eq("rst2_idle", 32'(dut.state_q), 32'd0);
    check_eq("rst2_empty", {31'd0, empty}, 32'd1);
    check_eq("rst2_hist", hist, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (3000) @(negedge clk);
    check_state("post_rst");
    check_eq("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
